// File: rtl/decoder4to16_strobe.sv
// Decodes an accepted 4-bit code onto a registered one-hot strobe held for HOLD_CYCLES, then blanks for GAP_CYCLES.
// Output valid the cycle after the accept edge; in_ready is low outside IDLE, during cancel and during reset.
module decoder4to16_strobe #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter int unsigned GAP_CYCLES  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  in,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        cancel,
   output logic [15:0] out,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
   // Wraps when GAP_CYCLES is 0, but the GAP state is never entered in that case.
   localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [15:0] out_q, out_d;
   logic        done_q, done_d;
   logic        accept;

   assign in_ready = rst_n & (state_q == IDLE) & ~cancel;
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               out_d   = 16'h0001 << in;
               state_d = HOLD;
               cnt_d   = HOLD_LOAD;
            end
         end
         HOLD: begin
            // Cancel shares the completion path so the gap is honoured either way.
            if (cancel || (cnt_q == 8'd0)) begin
               out_d  = 16'h0000;
               done_d = ~cancel;
               if (GAP_CYCLES != 0) begin
                  state_d = GAP;
                  cnt_d   = GAP_LOAD;
               end else begin
                  state_d = IDLE;
                  cnt_d   = 8'd0;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         GAP: begin
            if (cnt_q == 8'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
            out_d   = 16'h0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         out_q   <= 16'h0000;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   assign out  = out_q;
   assign done = done_q;
   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_decoder4to16_strobe.sv
// Scoreboarded bench: three instances (HOLD/GAP = 4/1, 1/0, 3/1) share one clock and reset.
`timescale 1ns/1ps
module tb_decoder4to16_strobe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic [3:0]  in_w   [3];
   logic        vld_w  [3];
   logic        cncl_w [3];
   logic        rdy_w  [3];
   logic        busy_w [3];
   logic        done_w [3];
   logic [15:0] out_w  [3];

   typedef struct {
      logic [15:0] val;
      int          len;
      logic        dn;
   } exp_t;

   exp_t exp_q [3][$];
   int   checks = 0;
   int   errors = 0;
   int   done_cnt [3];
   int   cyc = 0;

   always @(posedge clk) cyc = cyc + 1;

   decoder4to16_strobe #(.HOLD_CYCLES(4), .GAP_CYCLES(1)) u_a (
      .clk(clk), .rst_n(rst_n), .in(in_w[0]), .in_valid(vld_w[0]), .in_ready(rdy_w[0]),
      .cancel(cncl_w[0]), .out(out_w[0]), .busy(busy_w[0]), .done(done_w[0]));
   decoder4to16_strobe #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) u_b (
      .clk(clk), .rst_n(rst_n), .in(in_w[1]), .in_valid(vld_w[1]), .in_ready(rdy_w[1]),
      .cancel(cncl_w[1]), .out(out_w[1]), .busy(busy_w[1]), .done(done_w[1]));
   decoder4to16_strobe #(.HOLD_CYCLES(3), .GAP_CYCLES(1)) u_c (
      .clk(clk), .rst_n(rst_n), .in(in_w[2]), .in_valid(vld_w[2]), .in_ready(rdy_w[2]),
      .cancel(cncl_w[2]), .out(out_w[2]), .busy(busy_w[2]), .done(done_w[2]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks = checks + 1;
      if (act !== req) begin
         errors = errors + 1;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int k, input logic [15:0] val, input int len, input logic dn);
      exp_t e;
      e.val = val;
      e.len = len;
      e.dn  = dn;
      exp_q[k].push_back(e);
   endtask

   // Offers a code, waits for in_ready, and records what the resulting strobe must look like.
   task automatic send(input int k, input logic [3:0] code, input logic [15:0] val,
                       input int len, input logic dn);
      int n;
      n = 0;
      in_w[k]  = code;
      vld_w[k] = 1'b1;
      while (!rdy_w[k] && n < 50) begin
         step();
         n++;
      end
      if (!rdy_w[k]) begin
         check($sformatf("d%0d_send_timeout", k), 32'(rdy_w[k]), 32'd1);
         vld_w[k] = 1'b0;
         return;
      end
      push_exp(k, val, len, dn);
      step();
      vld_w[k] = 1'b0;
   endtask

   task automatic wait_idle(input int k);
      int n;
      n = 0;
      while (busy_w[k] && n < 600) begin
         step();
         n++;
      end
      check($sformatf("d%0d_idle_timeout", k), 32'(busy_w[k]), 32'd0);
   endtask

   // Monitor: reconstructs each strobe from the output and scores it against the queue.
   for (genvar g = 0; g < 3; g++) begin : g_mon
      int          run_len = 0;
      logic [15:0] run_val = '0;
      always @(negedge clk) begin
         exp_t e;
         if (done_w[g] === 1'b1) done_cnt[g] = done_cnt[g] + 1;
         if (out_w[g] !== 16'h0000) begin
            check($sformatf("d%0d_onehot", g), 32'($onehot(out_w[g])), 32'd1);
            check($sformatf("d%0d_done_with_out", g), 32'(done_w[g]), 32'd0);
            if (run_len == 0) run_val = out_w[g];
            else check($sformatf("d%0d_out_stable", g), 32'(out_w[g]), 32'(run_val));
            run_len++;
         end else if (run_len > 0) begin
            if (exp_q[g].size() == 0) begin
               check($sformatf("d%0d_unexpected_strobe", g), 32'(run_val), 32'd0);
            end else begin
               e = exp_q[g].pop_front();
               check($sformatf("d%0d_strobe_val", g), 32'(run_val), 32'(e.val));
               check($sformatf("d%0d_strobe_len", g), 32'(run_len), 32'(e.len));
               check($sformatf("d%0d_strobe_done", g), 32'(done_w[g]), 32'(e.dn));
            end
            run_len = 0;
         end else begin
            check($sformatf("d%0d_spurious_done", g), 32'(done_w[g]), 32'd0);
         end
      end
   end

   initial begin
      int last;
      for (int k = 0; k < 3; k++) begin
         in_w[k]     = 4'h0;
         vld_w[k]    = 1'b0;
         cncl_w[k]   = 1'b0;
         done_cnt[k] = 0;
      end

      // Reset and idle
      for (int c = 0; c < 3; c++) begin
         step();
         for (int k = 0; k < 3; k++) begin
            check($sformatf("d%0d_rst_out", k), 32'(out_w[k]), 32'd0);
            check($sformatf("d%0d_rst_done", k), 32'(done_w[k]), 32'd0);
            check($sformatf("d%0d_rst_busy", k), 32'(busy_w[k]), 32'd0);
            check($sformatf("d%0d_rst_rdy", k), 32'(rdy_w[k]), 32'd0);
         end
      end
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) check($sformatf("d%0d_rdy_after_rst", k), 32'(rdy_w[k]), 32'd1);
      step();

      // Single strobe, HOLD=4 GAP=1
      send(0, 4'hA, 16'h0400, 4, 1'b1);
      check("a_out_first", 32'(out_w[0]), 32'h0400);
      check("a_busy_hold", 32'(busy_w[0]), 32'd1);
      check("a_rdy_hold", 32'(rdy_w[0]), 32'd0);
      repeat (4) step();
      check("a_out_cleared", 32'(out_w[0]), 32'd0);
      check("a_done_pulse", 32'(done_w[0]), 32'd1);
      check("a_rdy_gap", 32'(rdy_w[0]), 32'd0);
      step();
      check("a_rdy_back", 32'(rdy_w[0]), 32'd1);
      check("a_done_one_cycle", 32'(done_w[0]), 32'd0);

      // Back-to-back sweep, HOLD=1 GAP=0
      vld_w[1] = 1'b1;
      last = 0;
      for (int i = 0; i < 16; i++) begin
         int n;
         n = 0;
         in_w[1] = 4'(i);
         while (!rdy_w[1] && n < 50) begin
            step();
            n++;
         end
         if (!rdy_w[1]) begin
            check("b_sweep_timeout", 32'(rdy_w[1]), 32'd1);
            break;
         end
         if (i > 0) check("b_sweep_spacing", 32'(cyc - last), 32'd2);
         last = cyc;
         push_exp(1, 16'(16'h0001 << i), 1, 1'b1);
         step();
      end
      vld_w[1] = 1'b0;
      wait_idle(1);
      repeat (3) step();
      check("b_done_count", 32'(done_cnt[1]), 32'd16);

      // Cancel on last hold cycle, HOLD=3 GAP=1
      send(2, 4'h3, 16'h0008, 3, 1'b0);
      step();
      step();
      check("c_out_last_hold", 32'(out_w[2]), 32'h0008);
      cncl_w[2] = 1'b1;
      step();
      cncl_w[2] = 1'b0;
      check("c_out_after_cancel", 32'(out_w[2]), 32'd0);
      check("c_no_done", 32'(done_w[2]), 32'd0);
      check("c_gap_busy", 32'(busy_w[2]), 32'd1);
      check("c_gap_rdy", 32'(rdy_w[2]), 32'd0);
      step();
      check("c_idle_busy", 32'(busy_w[2]), 32'd0);
      check("c_idle_rdy", 32'(rdy_w[2]), 32'd1);

      // Cancel in IDLE blocks accept
      in_w[0]   = 4'h5;
      vld_w[0]  = 1'b1;
      cncl_w[0] = 1'b1;
      #1;
      check("a_idle_cancel_rdy", 32'(rdy_w[0]), 32'd0);
      step();
      check("a_idle_cancel_busy", 32'(busy_w[0]), 32'd0);
      check("a_idle_cancel_out", 32'(out_w[0]), 32'd0);
      cncl_w[0] = 1'b0;
      #1;
      check("a_uncancel_rdy", 32'(rdy_w[0]), 32'd1);
      push_exp(0, 16'h0020, 4, 1'b1);
      step();
      vld_w[0] = 1'b0;
      check("a_accept_after_cancel", 32'(out_w[0]), 32'h0020);
      wait_idle(0);
      step();

      // Async reset mid-HOLD
      send(0, 4'hF, 16'h8000, 2, 1'b0);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("a_arst_out", 32'(out_w[0]), 32'd0);
      check("a_arst_busy", 32'(busy_w[0]), 32'd0);
      check("a_arst_rdy", 32'(rdy_w[0]), 32'd0);
      check("a_arst_done", 32'(done_w[0]), 32'd0);
      step();
      check("a_arst_hold_out", 32'(out_w[0]), 32'd0);
      rst_n = 1'b1;
      #1;
      check("a_rel_rdy", 32'(rdy_w[0]), 32'd1);
      send(0, 4'h7, 16'h0080, 4, 1'b1);
      check("a_fresh_out", 32'(out_w[0]), 32'h0080);
      wait_idle(0);

      repeat (5) step();
      for (int k = 0; k < 3; k++)
         check($sformatf("d%0d_queue_drained", k), 32'(exp_q[k].size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
